pipelined_adder: RTL and testbench

//  Parametrised, pipelined ripple-carry add/subtract unit for the CPU datapath ALU.

---
 rtl/adder_pkg.sv | 25 ++
 rtl/adder_chunk.sv | 25 ++
 rtl/pipelined_adder.sv | 129 ++++++++++++
 tb/tb_pipelined_adder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared defaults, stage record and helpers for the pipelined add/subtract unit.
package adder_pkg;

  localparam int unsigned ADDER_WIDTH  = 32;
  localparam int unsigned ADDER_STAGES = 4;

  // Stage record at the default width; pipelined_adder declares the same shape at its own WIDTH.
  typedef struct packed {
    logic                   valid;
    logic                   carry;
    logic [ADDER_WIDTH-1:0] sum;
    logic [ADDER_WIDTH-1:0] x_up;
    logic [ADDER_WIDTH-1:0] b_up;
  } adder_stage_t;

  function automatic logic adder_cfg_ok(input int unsigned width, input int unsigned stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  // FullAdder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_adder(input logic a, input logic b, input logic c);
    return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational W-bit ripple-carry adder built from FullAdder cells.
module adder_chunk
  import adder_pkg::*;
#(
  parameter int unsigned W = ADDER_WIDTH / ADDER_STAGES
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cIn,
  output logic [W-1:0] s,
  output logic         cOut
);

  logic w_c;

  always_comb begin
    w_c = cIn;
    s   = '0;
    for (int unsigned i = 0; i < W; i++) begin
      {w_c, s[i]} = full_adder(x[i], y[i], w_c);
    end
    cOut = w_c;
  end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined chunked ripple-carry add/subtract with valid/ready handshake and flush.
// Define ADDER_FLAGS_EN to compute and pipe the v/n/z flags; otherwise they are tied 0.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = ADDER_WIDTH,
  parameter int unsigned STAGES = ADDER_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cIn,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cOut,
  output logic             v,
  output logic             n,
  output logic             z
);

  localparam int unsigned CHUNK = WIDTH / STAGES;
  localparam int unsigned LAST  = STAGES - 1;

  if (!adder_cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a multiple of STAGES, with 1 <= STAGES <= WIDTH");
  end

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] x_up;
    logic [WIDTH-1:0] b_up;
  } stage_t;

  stage_t r_stg [STAGES];
  stage_t w_nxt [STAGES];
  logic   w_adv;

  assign w_adv     = !r_stg[LAST].valid || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_stg[LAST].valid;
  assign s         = r_stg[LAST].sum;
  assign cOut      = r_stg[LAST].carry;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t           w_in;
    stage_t           w_res;
    logic [CHUNK-1:0] w_s;
    logic             w_co;

    if (k == 0) begin : g_head
      always_comb begin
        w_in       = '0;
        w_in.valid = in_valid;
        w_in.carry = cIn ^ sub;
        w_in.x_up  = x;
        w_in.b_up  = sub ? ~y : y;
      end
    end else begin : g_body
      assign w_in = r_stg[k-1];
    end

    adder_chunk #(.W(CHUNK)) u_chunk (
      .x    (w_in.x_up[k*CHUNK +: CHUNK]),
      .y    (w_in.b_up[k*CHUNK +: CHUNK]),
      .cIn  (w_in.carry),
      .s    (w_s),
      .cOut (w_co)
    );

    always_comb begin
      w_res                         = w_in;
      w_res.sum[k*CHUNK +: CHUNK]   = w_s;
      w_res.carry                   = w_co;
    end

    assign w_nxt[k] = w_res;

    // flush only squashes valid bits; data may keep stale contents
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_stg[k] <= '0;
      end else if (flush) begin
        r_stg[k].valid <= 1'b0;
      end else if (w_adv) begin
        r_stg[k] <= w_nxt[k];
      end
    end
  end

  logic w_unused_operands;
  assign w_unused_operands = ^{r_stg[LAST].x_up, r_stg[LAST].b_up};

`ifdef ADDER_FLAGS_EN
  logic r_v;
  logic r_n;
  logic r_z;

  // Flags are derived from the fully resolved sum as it enters the output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= 1'b0;
      r_n <= 1'b0;
      r_z <= 1'b0;
    end else if (!flush && w_adv) begin
      r_v <= (w_nxt[LAST].x_up[WIDTH-1] == w_nxt[LAST].b_up[WIDTH-1]) &&
             (w_nxt[LAST].sum[WIDTH-1] != w_nxt[LAST].x_up[WIDTH-1]);
      r_n <= w_nxt[LAST].sum[WIDTH-1];
      r_z <= (w_nxt[LAST].sum == '0);
    end
  end

  assign v = r_v;
  assign n = r_n;
  assign z = r_z;
`else
  assign v = 1'b0;
  assign n = 1'b0;
  assign z = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder (WIDTH=32, STAGES=4).
`timescale 1ns/1ps
module tb_pipelined_adder;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         cIn;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cOut;
  logic         v;
  logic         n;
  logic         z;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_adder #(.WIDTH(W), .STAGES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .cIn       (cIn),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cOut      (cOut),
    .v         (v),
    .n         (n),
    .z         (z)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    logic         n;
    logic         z;
  } res_t;

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b_in,
                                 input logic ci, input logic sb);
    logic [W:0]   t;
    logic [W-1:0] b;
    res_t         r;
    b   = sb ? ~b_in : b_in;
    t   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci ^ sb};
    r.s = t[W-1:0];
    r.c = t[W];
`ifdef ADDER_FLAGS_EN
    r.v = (a[W-1] == b[W-1]) && (r.s[W-1] != a[W-1]);
    r.n = r.s[W-1];
    r.z = (r.s == '0);
`else
    r.v = 1'b0;
    r.n = 1'b0;
    r.z = 1'b0;
`endif
    return r;
  endfunction

  res_t        exp_q [$];
  logic        mon_en = 1'b0;
  int unsigned n_res = 0;
  int unsigned first_cyc = 0;
  int unsigned last_cyc = 0;

  always @(negedge clk) begin
    res_t e;
    if (!rst_n || flush) begin
      exp_q.delete();
    end else if (mon_en) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_out", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("stream_s",    64'(s),    64'(e.s));
          check_eq("stream_cout", 64'(cOut), 64'(e.c));
          check_eq("stream_flags", 64'({v, n, z}), 64'({e.v, e.n, e.z}));
          if (n_res == 0) first_cyc = cyc;
          last_cyc = cyc;
          n_res++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(x, y, cIn, sub));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_single(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ci, input logic sb, input logic [W-1:0] es,
                            input logic ec, input logic ev, input logic en, input logic ez);
    logic [2:0] ef;
`ifdef ADDER_FLAGS_EN
    ef = {ev, en, ez};
`else
    ef = {ev, en, ez} & 3'b000;
`endif
    x = a; y = b; cIn = ci; sub = sb; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check_eq({tag, "_early"}, 64'(out_valid), 64'd0);
    tick();
    check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
    check_eq({tag, "_s"},     64'(s),         64'(es));
    check_eq({tag, "_cout"},  64'(cOut),      64'(ec));
    check_eq({tag, "_flags"}, 64'({v, n, z}), 64'(ef));
    tick();
    check_eq({tag, "_drain"}, 64'(out_valid), 64'd0);
  endtask

  logic [W-1:0] ops_x [16];
  logic [W-1:0] ops_y [16];
  logic         ops_c [16];
  logic         ops_s [16];

  task automatic run_stream(input string tag, input int unsigned stall_at);
    int unsigned  i = 0;
    int unsigned  c = 0;
    logic         acc;
    logic         stall;
    logic [W-1:0] held = '0;
    n_res  = 0;
    mon_en = 1'b1;
    while (i < 16 && c < 64) begin
      x = ops_x[i]; y = ops_y[i]; cIn = ops_c[i]; sub = ops_s[i]; in_valid = 1'b1;
      stall     = (stall_at != 0) && (c >= stall_at) && (c < stall_at + 3);
      out_ready = !stall;
      @(negedge clk);
      if (stall) begin
        check_eq({tag, "_stall_in_ready"},  64'(in_ready),  64'd0);
        check_eq({tag, "_stall_out_valid"}, 64'(out_valid), 64'd1);
        if (c == stall_at) held = s;
        else check_eq({tag, "_hold_s"}, 64'(s), 64'(held));
      end
      acc = in_ready;
      tick();
      if (acc) i++;
      c++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_eq({tag, "_all_sent"}, 64'(i), 64'd16);
    for (int k = 0; k < 12 && n_res < 16; k++) tick();
    check_eq({tag, "_count"}, 64'(n_res), 64'd16);
    check_eq({tag, "_leftover"}, 64'(exp_q.size()), 64'd0);
    if (stall_at == 0) check_eq({tag, "_one_per_cycle"}, 64'(last_cyc - first_cyc), 64'd15);
    mon_en = 1'b0;
  endtask

  initial begin
    int unsigned seen;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; x = '0; y = '0;
    cIn = 1'b0; sub = 1'b0; out_ready = 1'b1;
    #3;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_s",         64'(s),         64'd0);
    check_eq("rst_cout",      64'(cOut),      64'd0);
    check_eq("rst_flags",     64'({v, n, z}), 64'd0);
    #19 rst_n = 1'b1;
    tick();
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);

    run_single("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
    run_single("sub_neg",   32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0);
    run_single("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
    run_single("sub_cin",   32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0, 1'b0, 1'b0);
    run_single("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    run_single("add_chain", 32'h1234_5678, 32'h0000_FFFF, 1'b1, 1'b0, 32'h1235_5678, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      ops_x[i] = $urandom();
      ops_y[i] = $urandom();
      ops_c[i] = 1'($urandom_range(0, 1));
      ops_s[i] = 1'($urandom_range(0, 1));
    end
    ops_x[3] = 32'hFFFF_FFFF; ops_y[3] = 32'h0; ops_c[3] = 1'b1; ops_s[3] = 1'b0;
    ops_x[9] = 32'h0000_0000; ops_y[9] = 32'h0; ops_c[9] = 1'b0; ops_s[9] = 1'b1;
    run_stream("stream", 0);
    run_stream("stall", 6);

    for (int i = 0; i < 3; i++) begin
      x = 32'h0000_1000 + 32'(i); y = 32'h0000_0001; cIn = 1'b0; sub = 1'b0; in_valid = 1'b1;
      tick();
    end
    x = 32'h0000_2000; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_eq("flush_drop", 64'(seen), 64'd0);
    tick();
    run_single("post_flush", 32'h0000_0100, 32'h0000_0023, 1'b0, 1'b0, 32'h0000_0123, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      x = 32'h1111_0000 + 32'(i); y = 32'h0000_2222; cIn = 1'b0; sub = 1'b0; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    #2;
    check_eq("pre_rst_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", 64'(out_valid), 64'd0);
    check_eq("arst_s",         64'(s),         64'd0);
    check_eq("arst_cout",      64'(cOut),      64'd0);
    check_eq("arst_flags",     64'({v, n, z}), 64'd0);
    #12 rst_n = 1'b1;
    tick();
    check_eq("arst_in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_eq("arst_discard", 64'(seen), 64'd0);
    tick();
    run_single("rerun_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
